// File: rtl/iram_loader.sv
`default_nettype none
// ============================================================================
// Module      : iram_loader
// Description : Boot-time instruction RAM loader. Assembles a little-endian
//               byte stream into 32-bit words and writes them sequentially
//               from word address 0. The core is held halted while a load
//               is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module iram_loader #(
    parameter int DW        = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start_i,
    input  logic [$clog2(MEM_DEPTH):0]   load_len_i,
    input  logic                         load_abort_i,
    input  logic                         byte_valid_i,
    input  logic [7:0]                   byte_data_i,
    output logic                         byte_ready_o,
    output logic                         ram_wen_o,
    output logic [$clog2(MEM_DEPTH)-1:0] ram_waddr_o,
    output logic [DW-1:0]                ram_wdata_o,
    output logic                         core_halt_o,
    output logic                         busy_o,
    output logic                         load_done_o,
    output logic                         load_err_o
);

    localparam int c_AW = $clog2(MEM_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [c_AW:0]   c_MAX_LEN = MEM_DEPTH[c_AW:0];
    localparam logic [c_AW:0]   c_LEN_ONE = 1;
    localparam logic [c_AW-1:0] c_IDX_ONE = 1;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_AW:0]   r_len;
    logic [c_AW-1:0] r_widx;
    logic [1:0]      r_bcnt;
    logic [23:0]     r_data;       // lower three byte lanes; the fourth arrives with the write
    logic [c_AW-1:0] r_waddr;
    logic [DW-1:0]   r_wdata;
    logic            r_err;

    logic w_len_bad;
    logic w_start_ok;
    logic w_start_bad;
    logic w_active;
    logic w_abort;
    logic w_accept;
    logic w_last_word;

    assign w_len_bad   = (load_len_i == '0) || (load_len_i > c_MAX_LEN);
    assign w_start_ok  = (r_state == c_IDLE) && load_start_i && !w_len_bad;
    assign w_start_bad = (r_state == c_IDLE) && load_start_i && w_len_bad;
    assign w_active    = (r_state == c_RECV) || (r_state == c_WRITE);
    assign w_abort     = w_active && load_abort_i;
    // Abort wins over byte acceptance so an aborted cycle never consumes a byte.
    assign w_accept    = (r_state == c_RECV) && byte_valid_i && !load_abort_i;
    assign w_last_word = ({1'b0, r_widx} == (r_len - c_LEN_ONE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        w_state_nxt  = r_state;
        byte_ready_o = 1'b0;
        ram_wen_o    = 1'b0;
        core_halt_o  = 1'b0;
        busy_o       = 1'b0;
        load_done_o  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = c_RECV;
                end
            end
            c_RECV: begin
                byte_ready_o = 1'b1;
                core_halt_o  = 1'b1;
                busy_o       = 1'b1;
                if (load_abort_i) begin
                    w_state_nxt = c_IDLE;
                end else if (byte_valid_i && (r_bcnt == 2'd3)) begin
                    w_state_nxt = c_WRITE;
                end
            end
            c_WRITE: begin
                ram_wen_o   = 1'b1;
                core_halt_o = 1'b1;
                busy_o      = 1'b1;
                if (load_abort_i) begin
                    w_state_nxt = c_IDLE;
                end else if (w_last_word) begin
                    w_state_nxt = c_DONE;
                end else begin
                    w_state_nxt = c_RECV;
                end
            end
            c_DONE: begin
                load_done_o = 1'b1;
                core_halt_o = 1'b1;
                busy_o      = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Datapath: length latch, byte assembly, word index and write registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_widx  <= '0;
            r_bcnt  <= 2'd0;
            r_data  <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_start_bad || w_abort;

            if (w_start_ok) begin
                r_len  <= load_len_i;
                r_widx <= '0;
                r_bcnt <= 2'd0;
            end

            if (w_abort) begin
                r_bcnt <= 2'd0;
            end

            if (w_accept) begin
                r_bcnt <= r_bcnt + 2'd1;
                case (r_bcnt)
                    2'd0: r_data[7:0]   <= byte_data_i;
                    2'd1: r_data[15:8]  <= byte_data_i;
                    2'd2: r_data[23:16] <= byte_data_i;
                    default: begin
                        // Fourth byte: capture the complete word for the WRITE cycle.
                        r_waddr <= r_widx;
                        r_wdata <= {byte_data_i, r_data};
                    end
                endcase
            end

            if ((r_state == c_WRITE) && !load_abort_i && !w_last_word) begin
                r_widx <= r_widx + c_IDX_ONE;
            end
        end
    end

    assign ram_waddr_o = r_waddr;
    assign ram_wdata_o = r_wdata;
    assign load_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_iram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_iram_loader
// Description : Self-checking bench for iram_loader with randomized byte
//               streams, stalls, aborts and resets against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iram_loader;

    localparam int DW        = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int AW        = $clog2(MEM_DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start_i;
    logic [AW:0]   load_len_i;
    logic          load_abort_i;
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          ram_wen_o;
    logic [AW-1:0] ram_waddr_o;
    logic [DW-1:0] ram_wdata_o;
    logic          core_halt_o;
    logic          busy_o;
    logic          load_done_o;
    logic          load_err_o;

    iram_loader #(.DW(DW), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .load_abort_i (load_abort_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .ram_wen_o    (ram_wen_o),
        .ram_waddr_o  (ram_waddr_o),
        .ram_wdata_o  (ram_wdata_o),
        .core_halt_o  (core_halt_o),
        .busy_o       (busy_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Byte stream for the current load; word k is tx[4k+3..4k] little-endian.
    logic [7:0] tx [0:4*MEM_DEPTH-1];

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          c;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  err_q[$];
    int  halt_cnt = 0;
    wr_t mon_w;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observed-event log, sampled on the inactive edge.
    always @(negedge clk) begin
        if (ram_wen_o) begin
            mon_w.addr = int'(ram_waddr_o);
            mon_w.data = ram_wdata_o;
            mon_w.c    = cyc;
            wr_q.push_back(mon_w);
            check_eq("ready_low_in_write", byte_ready_o, 0);
        end
        if (load_done_o) done_q.push_back(cyc);
        if (load_err_o)  err_q.push_back(cyc);
        if (core_halt_o) halt_cnt++;
    end

    task automatic clear_logs();
        @(negedge clk);
        wr_q.delete();
        done_q.delete();
        err_q.delete();
        halt_cnt = 0;
    endtask

    // Returns s = index of the edge that samples the start request.
    task automatic start_load(input int len, output int s);
        @(negedge clk);
        load_start_i = 1'b1;
        load_len_i   = len[AW:0];
        s            = cyc + 1;
        @(negedge clk);
        load_start_i = 1'b0;
    endtask

    // Streams tx[0..n-1]; optional extra start pulse once ign_at bytes went through.
    task automatic send_bytes(input int n, input int gap_pct, input int ign_at);
        int k      = 0;
        int budget = n * 20 + 50;
        while (k < n) begin
            if (budget == 0) begin
                check_eq("stream_timeout", k, n);
                break;
            end
            budget--;
            load_start_i = (ign_at >= 0) && (k == ign_at);
            load_len_i   = 1;
            byte_valid_i = ($urandom_range(99) >= gap_pct);
            byte_data_i  = tx[k];
            if (byte_ready_o && byte_valid_i) k++;
            @(negedge clk);
        end
        byte_valid_i = 1'b0;
        load_start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 50;
        while (busy_o && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("idle_timeout", busy_o, 0);
        @(negedge clk);
    endtask

    task automatic fill_random(input int nbytes);
        for (int i = 0; i < nbytes; i++) tx[i] = 8'($urandom);
    endtask

    // Word-level reference: writes at k = 0..len-1, done one cycle after the last.
    task automatic check_load(input int len, input int s, input bit timed);
        check_eq("wr_count", wr_q.size(), len);
        for (int k = 0; k < len && k < wr_q.size(); k++) begin
            check_eq("wr_addr", wr_q[k].addr, k);
            check_eq("wr_data", wr_q[k].data, {tx[4*k+3], tx[4*k+2], tx[4*k+1], tx[4*k]});
            if (timed) check_eq("wr_cycle", wr_q[k].c, s + 4 + 5 * k);
        end
        check_eq("done_count", done_q.size(), 1);
        if (done_q.size() == 1 && wr_q.size() > 0)
            check_eq("done_after_last_wr", done_q[0], wr_q[$].c + 1);
        check_eq("err_count", err_q.size(), 0);
        if (timed) check_eq("halt_cycles", halt_cnt, 5 * len + 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {byte_ready_o, ram_wen_o, core_halt_o, busy_o, load_done_o, load_err_o}, 0);
        check_eq({tag, "_waddr"}, ram_waddr_o, 0);
        check_eq({tag, "_wdata"}, ram_wdata_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int s;
        int len;
        rst          = 1'b1;
        load_start_i = 1'b0;
        load_len_i   = '0;
        load_abort_i = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst = 1'b0;

        // Single word, back-to-back bytes.
        clear_logs();
        tx[0] = 8'h78; tx[1] = 8'h56; tx[2] = 8'h34; tx[3] = 8'h12;
        start_load(1, s);
        send_bytes(4, 0, -1);
        wait_idle();
        check_load(1, s, 1'b1);
        if (wr_q.size() > 0) check_eq("single_word", wr_q[0].data, 32'h1234_5678);

        // Stalled stream with a fixed byte ramp.
        clear_logs();
        for (int i = 0; i < 12; i++) tx[i] = 8'(i);
        start_load(3, s);
        send_bytes(12, 50, -1);
        wait_idle();
        check_load(3, s, 1'b0);

        // Illegal lengths.
        clear_logs();
        start_load(0, s);
        check_eq("len0_err", load_err_o, 1);
        check_eq("len0_busy", busy_o, 0);
        @(negedge clk);
        check_eq("len0_err_pulse", load_err_o, 0);
        start_load(MEM_DEPTH + 1, s);
        check_eq("lenmax_err", load_err_o, 1);
        check_eq("lenmax_busy", busy_o, 0);
        @(negedge clk);
        check_eq("illegal_err_count", err_q.size(), 2);
        check_eq("illegal_no_write", wr_q.size(), 0);
        check_eq("illegal_halt", halt_cnt, 0);

        // Randomized loads with stalls and an ignored mid-load start.
        for (int t = 0; t < 6; t++) begin
            clear_logs();
            len = $urandom_range(1, 6);
            fill_random(4 * len);
            start_load(len, s);
            send_bytes(4 * len, 40, $urandom_range(1, 4 * len - 1));
            wait_idle();
            check_load(len, s, 1'b0);
        end

        // Abort in RECV after 2 bytes of word 1, with a byte offered the same cycle.
        clear_logs();
        fill_random(16);
        start_load(4, s);
        send_bytes(6, 0, -1);
        load_abort_i = 1'b1;
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hA5;
        @(negedge clk);
        load_abort_i = 1'b0;
        byte_valid_i = 1'b0;
        check_eq("abort_recv_err", load_err_o, 1);
        check_eq("abort_recv_busy", busy_o, 0);
        @(negedge clk);
        check_eq("abort_recv_wr_count", wr_q.size(), 1);
        if (wr_q.size() > 0)
            check_eq("abort_recv_word0", wr_q[0].data, {tx[3], tx[2], tx[1], tx[0]});
        check_eq("abort_recv_no_done", done_q.size(), 0);
        check_eq("abort_recv_err_count", err_q.size(), 1);

        // Abort landing on a WRITE cycle: the write still happens.
        clear_logs();
        fill_random(8);
        start_load(2, s);
        send_bytes(4, 0, -1);
        load_abort_i = 1'b1;
        @(negedge clk);
        load_abort_i = 1'b0;
        check_eq("abort_wr_err", load_err_o, 1);
        check_eq("abort_wr_busy", busy_o, 0);
        @(negedge clk);
        check_eq("abort_wr_count", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            check_eq("abort_wr_addr", wr_q[0].addr, 0);
            check_eq("abort_wr_data", wr_q[0].data, {tx[3], tx[2], tx[1], tx[0]});
        end
        check_eq("abort_wr_no_done", done_q.size(), 0);

        // Full depth, no stalls.
        clear_logs();
        fill_random(4 * MEM_DEPTH);
        start_load(MEM_DEPTH, s);
        send_bytes(4 * MEM_DEPTH, 0, -1);
        wait_idle();
        check_load(MEM_DEPTH, s, 1'b1);
        if (wr_q.size() > 0) check_eq("full_last_addr", wr_q[$].addr, MEM_DEPTH - 1);

        // Reset during RECV of word 2, then a fresh single-word load.
        clear_logs();
        fill_random(16);
        start_load(4, s);
        send_bytes(10, 0, -1);
        check_eq("pre_reset_busy", busy_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        fill_random(4);
        start_load(1, s);
        send_bytes(4, 0, -1);
        wait_idle();
        check_load(1, s, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iram_loader.md
# iram_loader

Boot-time program loader for the instruction RAM. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them sequentially from word address 0 into the write port of the instruction RAM's dual-port memory, holding the core halted for the whole load. It sits between the debug/UART receiver and the RAM write port; the fetch read port is untouched.

## Interface
- DW, 32, data width of RAM words; only 32 is supported.
- MEM_DEPTH, 1024, RAM depth in words; AW = $clog2(MEM_DEPTH) is derived locally.

- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_start_i  input  1  start request; sampled only in IDLE.
- load_len_i  input  AW+1  load length in words; sampled with load_start_i; legal range 1..MEM_DEPTH.
- load_abort_i  input  1  abort an active load.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- ram_wen_o  output  1  RAM write enable.
- ram_waddr_o  output  AW  RAM word address.
- ram_wdata_o  output  DW  RAM write data.
- core_halt_o  output  1  core must not fetch or retire.
- busy_o  output  1  load in progress (state != IDLE).
- load_done_o  output  1  one-cycle pulse: all words written.
- load_err_o  output  1  one-cycle pulse: illegal length or abort.

## Operation
- Reset values: state IDLE, word index 0, byte count 0, data register 0; all outputs 0.
- The FSM has four states: IDLE, RECV, WRITE and DONE. Outputs are Moore decodes of the state, except load_err_o, which is a register.
- **IDLE.** byte_ready_o=0 and core_halt_o=0.
  - load_start_i with load_len_i==0 or load_len_i>MEM_DEPTH: load_err_o pulses on the next cycle and the FSM stays in IDLE.
  - load_start_i with a legal length: latch the length, clear word index and byte count, go to RECV.
- **RECV.** byte_ready_o=1 and core_halt_o=1.
  - Each accepted byte (byte_valid_i & byte_ready_o) is stored in lane byte_cnt: the first byte goes to [7:0] and the fourth to [31:24]. byte_cnt then increments.
  - Accepting the fourth byte goes to WRITE and byte_cnt wraps to 0.
  - When byte_valid_i is low, the state is held with no timeout.
- **WRITE.** ram_wen_o=1 for exactly one cycle, with ram_waddr_o = word index and ram_wdata_o = the assembled word. byte_ready_o=0.
  - If word index == length-1, go to DONE.
  - Otherwise increment the word index and go to RECV.
- **DONE.** load_done_o=1 and core_halt_o=1 for one cycle, then return to IDLE.
- ram_waddr_o and ram_wdata_o hold their last values outside WRITE. They are meaningful only while ram_wen_o=1.
- load_start_i is ignored in RECV, WRITE and DONE.
- **Abort.** load_abort_i in RECV or WRITE causes the following:
  - The FSM goes to IDLE on the next edge and load_err_o pulses.
  - Partial bytes are discarded.
  - A WRITE in that cycle still completes its write.
  - Abort in IDLE or DONE is ignored.
  - Abort has priority over byte acceptance in the same cycle, so no byte is consumed.
- **Address range.** The word index never exceeds MEM_DEPTH-1, so addresses never wrap. Words already written persist after an abort or reset.

## Timing
- Start to first byte_ready_o: 1 cycle (the start is registered into RECV).
- Per word: at least 5 cycles (4 accepts plus 1 WRITE).
- Full load with no stalls: 1 + 5*N + 1 cycles from the start edge to IDLE.
- load_done_o is asserted one cycle after the last ram_wen_o. core_halt_o falls on the cycle after load_done_o.
- load_err_o occurs one cycle after the offending start, or one cycle after the abort.
- rst assertion at any time forces all outputs to 0 immediately (asynchronously) and the FSM to IDLE. The first start is accepted on the first clk edge after rst deasserts.

## Test plan
- **Single word.** Drive len=1 and bytes 0x78,0x56,0x34,0x12 back-to-back. Required: one write of addr 0, data 0x12345678, ram_wen_o for 1 cycle, load_done_o 1 cycle later, core_halt_o high from cycle 1 through DONE.
- **Stalled stream.** Drive len=3 with bytes 0x00..0x0B and random byte_valid_i gaps. Required: writes of addr0=0x03020100, addr1=0x07060504, addr2=0x0B0A0908, with byte_ready_o low during each WRITE.
- **Illegal lengths.** Drive len=0, then len=MEM_DEPTH+1. Required: load_err_o pulses each time, busy_o stays 0, no ram_wen_o.
- **Full depth.** Drive len=MEM_DEPTH. Required: the last write is at addr MEM_DEPTH-1, no wrap to 0, then load_done_o.
- **Abort and ignored start.**
  - Assert load_start_i again mid-load: it is ignored and the length is unchanged.
  - Abort after 2 bytes of word 1 (len=4): load_err_o pulses, no write for word 1, returns to IDLE, word 0 already written.
- **Reset mid-load.** Assert rst during RECV of word 2. Required: outputs go to 0 asynchronously. A new len=1 load then completes normally at addr 0.
